// File: rtl/axi4_lite_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi4_lite_master_if                                              |
// | Brief    : Command/response port plus AXI4-Lite bus for axi4_lite_master.   |
// |            Optional strobe ports appear with AXI_MASTER_WSTRB_EN.           |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface axi4_lite_master_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  in_cmd_valid;
  logic                  out_cmd_ready;
  logic                  in_cmd_write;
  logic [ADDR_WIDTH-1:0] in_cmd_addr;
  logic [DATA_WIDTH-1:0] in_cmd_wdata;
  logic                  out_rsp_valid;
  logic                  in_rsp_ready;
  logic [DATA_WIDTH-1:0] out_rsp_rdata;
  logic [1:0]            out_rsp_resp;
  logic [ADDR_WIDTH-1:0] out_m_araddr;
  logic                  out_m_arvalid;
  logic                  in_m_arready;
  logic [DATA_WIDTH-1:0] in_m_rdata;
  logic [1:0]            in_m_rresp;
  logic                  in_m_rvalid;
  logic                  out_m_rready;
  logic [ADDR_WIDTH-1:0] out_m_awaddr;
  logic                  out_m_awvalid;
  logic                  in_m_awready;
  logic [DATA_WIDTH-1:0] out_m_wdata;
  logic                  out_m_wvalid;
  logic                  in_m_wready;
  logic [1:0]            in_m_bresp;
  logic                  in_m_bvalid;
  logic                  out_m_bready;
`ifdef AXI_MASTER_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] in_cmd_wstrb;
  logic [DATA_WIDTH/8-1:0] out_m_wstrb;
`endif

  modport master (
`ifdef AXI_MASTER_WSTRB_EN
    input  in_cmd_wstrb,
    output out_m_wstrb,
`endif
    input  in_cmd_valid, in_cmd_write, in_cmd_addr, in_cmd_wdata, in_rsp_ready,
    input  in_m_arready, in_m_rdata, in_m_rresp, in_m_rvalid,
    input  in_m_awready, in_m_wready, in_m_bresp, in_m_bvalid,
    output out_cmd_ready, out_rsp_valid, out_rsp_rdata, out_rsp_resp,
    output out_m_araddr, out_m_arvalid, out_m_rready,
    output out_m_awaddr, out_m_awvalid, out_m_wdata, out_m_wvalid, out_m_bready
  );

  modport slave (
`ifdef AXI_MASTER_WSTRB_EN
    output in_cmd_wstrb,
    input  out_m_wstrb,
`endif
    output in_cmd_valid, in_cmd_write, in_cmd_addr, in_cmd_wdata, in_rsp_ready,
    output in_m_arready, in_m_rdata, in_m_rresp, in_m_rvalid,
    output in_m_awready, in_m_wready, in_m_bresp, in_m_bvalid,
    input  out_cmd_ready, out_rsp_valid, out_rsp_rdata, out_rsp_resp,
    input  out_m_araddr, out_m_arvalid, out_m_rready,
    input  out_m_awaddr, out_m_awvalid, out_m_wdata, out_m_wvalid, out_m_bready
  );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : axi4_lite_master                                                 |
// | Brief    : Single-outstanding AXI4-Lite initiator driven by a valid/ready   |
// |            command port. Macro AXI_MASTER_WSTRB_EN adds write strobes.      |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module axi4_lite_master #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic               aclk,
  input  logic               areset,
  axi4_lite_master_if.master bus
);

  localparam int                    c_ALIGN_BITS = (DATA_WIDTH == 64) ? 3 : 2;
  localparam logic [ADDR_WIDTH-1:0] c_ADDR_MASK  = {ADDR_WIDTH{1'b1}} << c_ALIGN_BITS;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    WAIT_B = 3'd2,
    READ   = 3'd3,
    WAIT_R = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_cmd_ready;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_resp;
`ifdef AXI_MASTER_WSTRB_EN
  logic [DATA_WIDTH/8-1:0] r_wstrb;
`endif

  // A channel is finished once its valid is low or is being accepted this cycle.
  logic w_aw_done;
  logic w_w_done;
  assign w_aw_done = ~r_awvalid | bus.in_m_awready;
  assign w_w_done  = ~r_wvalid  | bus.in_m_wready;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_resp      <= 2'b00;
`ifdef AXI_MASTER_WSTRB_EN
      r_wstrb     <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= bus.in_cmd_addr & c_ADDR_MASK;
            if (bus.in_cmd_write) begin
              r_wdata   <= bus.in_cmd_wdata;
`ifdef AXI_MASTER_WSTRB_EN
              r_wstrb   <= bus.in_cmd_wstrb;
`endif
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WRITE;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= READ;
            end
          end
        end
        WRITE: begin
          if (r_awvalid && bus.in_m_awready) r_awvalid <= 1'b0;
          if (r_wvalid && bus.in_m_wready)   r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WAIT_B;
          end
        end
        WAIT_B: begin
          if (bus.in_m_bvalid) begin
            r_bready    <= 1'b0;
            r_resp      <= bus.in_m_bresp;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        READ: begin
          if (bus.in_m_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= WAIT_R;
          end
        end
        WAIT_R: begin
          if (bus.in_m_rvalid) begin
            r_rready    <= 1'b0;
            r_rdata     <= bus.in_m_rdata;
            r_resp      <= bus.in_m_rresp;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
          end
        end
        RESP: begin
          // Idle (and ready) only from the cycle after the response handshake.
          if (bus.in_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.out_cmd_ready = r_cmd_ready;
  assign bus.out_rsp_valid = r_rsp_valid;
  assign bus.out_rsp_rdata = r_rdata;
  assign bus.out_rsp_resp  = r_resp;
  assign bus.out_m_araddr  = r_addr;
  assign bus.out_m_arvalid = r_arvalid;
  assign bus.out_m_rready  = r_rready;
  assign bus.out_m_awaddr  = r_addr;
  assign bus.out_m_awvalid = r_awvalid;
  assign bus.out_m_wdata   = r_wdata;
  assign bus.out_m_wvalid  = r_wvalid;
  assign bus.out_m_bready  = r_bready;
`ifdef AXI_MASTER_WSTRB_EN
  assign bus.out_m_wstrb   = r_wstrb;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_axi4_lite_master                                              |
// | Brief    : Directed vector bench for axi4_lite_master with a delay-         |
// |            configurable AXI4-Lite slave model.                              |
// | Revision : 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_axi4_lite_master;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_lite_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
  axi4_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (.aclk(clk), .areset(rst), .bus(bus));

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            a_d;       // AWREADY / ARREADY wait cycles
    int            w_d;       // WREADY wait cycles
    int            r_d;       // BVALID / RVALID wait cycles
    logic [DW-1:0] s_rdata;
    logic [1:0]    s_resp;
    int            stall;     // cycles in_rsp_ready is held low
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_rdata;
    logic [1:0]    exp_resp;
    int            exp_lat;
    int            exp_aw;
    int            exp_w;
    int            exp_ar;
  } vec_t;

  vec_t vecs [7];

  // Slave model configuration (written only by the stimulus process)
  int            cfg_a_d = 0;
  int            cfg_w_d = 0;
  int            cfg_r_d = 0;
  logic [DW-1:0] cfg_rdata = '0;
  logic [1:0]    cfg_resp = 2'b00;

  // Slave model state and monotonic statistics (written only by the slave)
  int aw_wait = 0, w_wait = 0, ar_wait = 0, b_wait = 0, r_wait = 0;
  logic aw_done = 1'b0, w_done = 1'b0, ar_done = 1'b0, b_drop = 1'b0, r_drop = 1'b0;
  logic aw_pend = 1'b0, w_pend = 1'b0, ar_pend = 1'b0;
  logic [AW-1:0] aw_hold = '0, ar_hold = '0;
  logic [DW-1:0] w_hold = '0;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, b_hs = 0, r_hs = 0;
  int aw_cyc = 0, w_cyc = 0, ar_cyc = 0, stab_err = 0, early_err = 0;
  logic [AW-1:0] seen_addr = '0;
  logic [DW-1:0] seen_wdata = '0;
`ifdef AXI_MASTER_WSTRB_EN
  logic [SW-1:0] seen_wstrb = '0;
`endif

  // Ready/valid decided at the negedge; a handshake happens at the next posedge.
  always @(negedge clk) begin
    bus.in_m_rdata = cfg_rdata;
    bus.in_m_rresp = cfg_resp;
    bus.in_m_bresp = cfg_resp;
    if (rst) begin
      bus.in_m_awready = 1'b0; bus.in_m_wready = 1'b0; bus.in_m_arready = 1'b0;
      bus.in_m_bvalid = 1'b0;  bus.in_m_rvalid = 1'b0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      aw_done = 1'b0; w_done = 1'b0; ar_done = 1'b0; b_drop = 1'b0; r_drop = 1'b0;
      aw_pend = 1'b0; w_pend = 1'b0; ar_pend = 1'b0;
    end else begin
      if (b_drop) begin
        bus.in_m_bvalid = 1'b0; b_drop = 1'b0;
      end else if (!bus.in_m_bvalid && aw_done && w_done) begin
        if (b_wait >= cfg_r_d) begin
          bus.in_m_bvalid = 1'b1; aw_done = 1'b0; w_done = 1'b0; b_wait = 0;
        end else b_wait++;
      end
      if (bus.in_m_bvalid && !b_drop && bus.out_m_bready) begin b_drop = 1'b1; b_hs++; end

      if (r_drop) begin
        bus.in_m_rvalid = 1'b0; r_drop = 1'b0;
      end else if (!bus.in_m_rvalid && ar_done) begin
        if (r_wait >= cfg_r_d) begin
          bus.in_m_rvalid = 1'b1; ar_done = 1'b0; r_wait = 0;
        end else r_wait++;
      end
      if (bus.in_m_rvalid && !r_drop && bus.out_m_rready) begin r_drop = 1'b1; r_hs++; end

      if (bus.out_m_awvalid) begin
        aw_cyc++;
        if (aw_pend && bus.out_m_awaddr != aw_hold) stab_err++;
        aw_pend = 1'b1; aw_hold = bus.out_m_awaddr;
        if (aw_wait >= cfg_a_d) begin
          bus.in_m_awready = 1'b1; aw_hs++; seen_addr = bus.out_m_awaddr;
          aw_done = 1'b1; aw_pend = 1'b0; aw_wait = 0;
        end else begin bus.in_m_awready = 1'b0; aw_wait++; end
      end else begin bus.in_m_awready = 1'b0; aw_wait = 0; aw_pend = 1'b0; end

      if (bus.out_m_wvalid) begin
        w_cyc++;
        if (w_pend && bus.out_m_wdata != w_hold) stab_err++;
        w_pend = 1'b1; w_hold = bus.out_m_wdata;
        if (w_wait >= cfg_w_d) begin
          bus.in_m_wready = 1'b1; w_hs++; seen_wdata = bus.out_m_wdata;
`ifdef AXI_MASTER_WSTRB_EN
          seen_wstrb = bus.out_m_wstrb;
`endif
          w_done = 1'b1; w_pend = 1'b0; w_wait = 0;
        end else begin bus.in_m_wready = 1'b0; w_wait++; end
      end else begin bus.in_m_wready = 1'b0; w_wait = 0; w_pend = 1'b0; end

      if (bus.out_m_arvalid) begin
        ar_cyc++;
        if (ar_pend && bus.out_m_araddr != ar_hold) stab_err++;
        ar_pend = 1'b1; ar_hold = bus.out_m_araddr;
        if (ar_wait >= cfg_a_d) begin
          bus.in_m_arready = 1'b1; ar_hs++; seen_addr = bus.out_m_araddr;
          ar_done = 1'b1; ar_pend = 1'b0; ar_wait = 0;
        end else begin bus.in_m_arready = 1'b0; ar_wait++; end
      end else begin bus.in_m_arready = 1'b0; ar_wait = 0; ar_pend = 1'b0; end

      if (bus.out_m_bready && (bus.out_m_awvalid || bus.out_m_wvalid || bus.out_m_arvalid || bus.out_m_rready))
        early_err++;
      if (bus.out_m_rready && (bus.out_m_awvalid || bus.out_m_wvalid || bus.out_m_arvalid))
        early_err++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_cmd_valid = 1'b1;
    bus.in_cmd_write = wr;
    bus.in_cmd_addr  = a;
    bus.in_cmd_wdata = d;
`ifdef AXI_MASTER_WSTRB_EN
    bus.in_cmd_wstrb = wr ? {(SW/2){2'b10}} : '0;
`endif
    while (bus.out_cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", bus.out_cmd_ready, 1);
    @(negedge clk);
    bus.in_cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 1;
    while (bus.out_rsp_valid !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic rsp_handshake();
    bus.in_rsp_ready = 1'b1;
    @(negedge clk);
    bus.in_rsp_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, bad;
    int aw_hs0, w_hs0, ar_hs0, b_hs0, r_hs0, aw_c0, w_c0, ar_c0, st0, ea0;
    logic [DW-1:0] rd;
    logic [1:0]    rs;
    cfg_a_d = v.a_d; cfg_w_d = v.w_d; cfg_r_d = v.r_d;
    cfg_rdata = v.s_rdata; cfg_resp = v.s_resp;
    aw_hs0 = aw_hs; w_hs0 = w_hs; ar_hs0 = ar_hs; b_hs0 = b_hs; r_hs0 = r_hs;
    aw_c0 = aw_cyc; w_c0 = w_cyc; ar_c0 = ar_cyc; st0 = stab_err; ea0 = early_err;
    issue(v.write, v.addr, v.wdata);
    wait_rsp(lat);
    check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
    rd = bus.out_rsp_rdata;
    rs = bus.out_rsp_resp;
    bad = 0;
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      if (bus.out_rsp_valid !== 1'b1 || bus.out_rsp_rdata !== rd || bus.out_rsp_resp !== rs ||
          bus.out_cmd_ready !== 1'b0) bad++;
    end
    check($sformatf("v%0d_rsp_hold", idx), bad, 0);
    rsp_handshake();
    check($sformatf("v%0d_rsp_done", idx), {bus.out_rsp_valid, bus.out_cmd_ready}, 2'b01);
    check($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
    check($sformatf("v%0d_resp", idx), rs, v.exp_resp);
    check($sformatf("v%0d_axi_addr", idx), seen_addr, v.exp_addr);
    check($sformatf("v%0d_aw_cycles", idx), aw_cyc - aw_c0, v.exp_aw);
    check($sformatf("v%0d_w_cycles", idx), w_cyc - w_c0, v.exp_w);
    check($sformatf("v%0d_ar_cycles", idx), ar_cyc - ar_c0, v.exp_ar);
    check($sformatf("v%0d_stable", idx), stab_err - st0, 0);
    check($sformatf("v%0d_ready_order", idx), early_err - ea0, 0);
    if (v.write) begin
      check($sformatf("v%0d_hs", idx), {8'(aw_hs - aw_hs0), 8'(w_hs - w_hs0), 8'(b_hs - b_hs0),
                                        8'(ar_hs - ar_hs0), 8'(r_hs - r_hs0)}, 40'h01_01_01_00_00);
      check($sformatf("v%0d_wdata", idx), seen_wdata, v.wdata);
`ifdef AXI_MASTER_WSTRB_EN
      check($sformatf("v%0d_wstrb", idx), seen_wstrb, {(SW/2){2'b10}});
`endif
    end else begin
      check($sformatf("v%0d_hs", idx), {8'(aw_hs - aw_hs0), 8'(w_hs - w_hs0), 8'(b_hs - b_hs0),
                                        8'(ar_hs - ar_hs0), 8'(r_hs - r_hs0)}, 40'h00_00_00_01_01);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bad, busy, ar0;
    logic [DW-1:0] rd;
    logic [1:0]    rs;
    bus.in_cmd_valid = 1'b0;
    bus.in_cmd_write = 1'b0;
    bus.in_cmd_addr  = '0;
    bus.in_cmd_wdata = '0;
    bus.in_rsp_ready = 1'b0;
`ifdef AXI_MASTER_WSTRB_EN
    bus.in_cmd_wstrb = '0;
`endif
    //          wr    addr     wdata         a  w  r  s_rdata       resp  stl exp_addr exp_rdata    eresp lat aw w ar
    vecs[0] = '{1'b1, 12'h014, 32'hDEADBEEF, 0, 0, 0, 32'h11111111, 2'b00, 0, 12'h014, 32'h0,        2'b00, 3, 1, 1, 0};
    vecs[1] = '{1'b1, 12'h023, 32'hCAFEF00D, 3, 0, 0, 32'h22222222, 2'b00, 1, 12'h020, 32'h0,        2'b00, 6, 4, 1, 0};
    vecs[2] = '{1'b0, 12'h008, 32'h0,        2, 0, 0, 32'h12345678, 2'b10, 0, 12'h008, 32'h12345678, 2'b10, 5, 0, 0, 3};
    vecs[3] = '{1'b1, 12'h101, 32'h0BADC0DE, 0, 2, 1, 32'h33333333, 2'b11, 3, 12'h100, 32'h0,        2'b11, 6, 1, 3, 0};
    vecs[4] = '{1'b0, 12'hFFF, 32'h0,        0, 0, 3, 32'hA5A50001, 2'b00, 0, 12'hFFC, 32'hA5A50001, 2'b00, 6, 0, 0, 1};
    vecs[5] = '{1'b1, 12'h3FE, 32'h01234567, 2, 2, 0, 32'h44444444, 2'b10, 0, 12'h3FC, 32'h0,        2'b10, 5, 3, 3, 0};
    vecs[6] = '{1'b0, 12'h7F0, 32'h0,        0, 0, 0, 32'h0000FFFF, 2'b11, 2, 12'h7F0, 32'h0000FFFF, 2'b11, 3, 0, 0, 1};

    // Reset held for three rising edges
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_valids", {bus.out_m_arvalid, bus.out_m_awvalid, bus.out_m_wvalid,
                             bus.out_m_rready, bus.out_m_bready, bus.out_rsp_valid}, 6'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", bus.out_cmd_ready, 1);
    check("reset_regs", {bus.out_m_awaddr, bus.out_rsp_rdata, bus.out_rsp_resp}, '0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // Response stalled 5 cycles while the next command waits
    cfg_a_d = 0; cfg_w_d = 0; cfg_r_d = 0; cfg_rdata = 32'h87654321; cfg_resp = 2'b00;
    ar0 = ar_hs;
    issue(1'b1, 12'h040, 32'h55AA55AA);
    wait_rsp(lat);
    check("stall_rsp_valid", bus.out_rsp_valid, 1);
    bus.in_cmd_valid = 1'b1;
    bus.in_cmd_write = 1'b0;
    bus.in_cmd_addr  = 12'h04A;
    rd = bus.out_rsp_rdata;
    rs = bus.out_rsp_resp;
    bad = 0;
    busy = 0;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      if (bus.out_rsp_valid !== 1'b1 || bus.out_rsp_rdata !== rd || bus.out_rsp_resp !== rs) bad++;
      if (bus.out_cmd_ready !== 1'b0) busy++;
    end
    check("stall_rsp_stable", bad, 0);
    check("stall_cmd_blocked", busy, 0);
    check("stall_write_rsp", {rd, rs}, {32'h0, 2'b00});
    rsp_handshake();
    check("stall_ready_after", bus.out_cmd_ready, 1);
    check("stall_no_early_read", ar_hs - ar0, 0);
    @(negedge clk);
    bus.in_cmd_valid = 1'b0;
    check("stall_next_accepted", {bus.out_cmd_ready, bus.out_m_arvalid}, 2'b01);
    check("stall_next_araddr", bus.out_m_araddr, 12'h048);
    wait_rsp(lat);
    check("stall_next_rdata", {bus.out_rsp_rdata, bus.out_rsp_resp}, {32'h87654321, 2'b00});
    rsp_handshake();

    // Reset in the middle of a write aborts it
    cfg_a_d = 10;
    issue(1'b1, 12'h200, 32'hFEEDFACE);
    @(negedge clk);
    check("midrst_busy", bus.out_m_awvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cleared", {bus.out_m_awvalid, bus.out_m_wvalid, bus.out_m_bready,
                             bus.out_rsp_valid, bus.out_cmd_ready}, 5'b00001);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", bus.out_cmd_ready, 1);
    run_vec(vecs[2], 7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
